// File: rtl/ascii_dump_sequencer_if.sv
// Requester and UART-side signals of the ASCII dump sequencer.
// The master modport is the sequencer's view; the slave modport is the environment's view.
interface ascii_dump_sequencer_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*7-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;

  modport master (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_data, tx_valid, busy
  );

  modport slave (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/ascii_dump_sequencer.sv
// Round-robin sharing of one bin_to_ascii converter among debug taps.
// Each granted word is streamed as "<id>:<b6..b0>\r\n" over valid/ready.
module bin_to_ascii (
  input  logic [6:0]  i_bin,
  output logic [55:0] o_ascii
);
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_chr
      assign o_ascii[8*gi +: 8] = i_bin[gi] ? 8'h31 : 8'h30;
    end
  endgenerate
endmodule

module ascii_dump_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  ascii_dump_sequencer_if.master bus
);
  generate
    if (DATA_W != 7) begin : g_bad_data_w
      $error("ascii_dump_sequencer: DATA_W must be 7");
    end
    if (NUM_REQ < 1 || NUM_REQ > 10) begin : g_bad_num_req
      $error("ascii_dump_sequencer: NUM_REQ must be 1..10");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t      r_state;
  logic [3:0]  r_index;
  logic [3:0]  r_id;
  logic [3:0]  r_last_grant;
  logic [6:0]  r_word;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;

  logic [9:0]         w_valid_ext;
  logic [3:0]         w_cand [NUM_REQ];
  logic               w_found;
  logic [3:0]         w_grant_id;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_take;
  logic [55:0]        w_ascii;
  logic [3:0]         w_next_idx;
  logic [7:0]         w_next_byte;

  assign w_valid_ext = 10'(bus.req_valid);

  // Candidate order: last_grant+1, last_grant+2, ... wrapping modulo NUM_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign w_cand[gi] = 4'((32'(r_last_grant) + 32'(gi) + 32'd1) % NUM_REQ);
    end
  endgenerate

  // Scan from the far end so the nearest candidate wins.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = 4'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_valid_ext[w_cand[k]]) begin
        w_found    = 1'b1;
        w_grant_id = w_cand[k];
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign w_req_ready[gi] = (r_state == ST_IDLE) && !rst && w_found &&
                               (w_grant_id == 4'(gi));
    end
  endgenerate

  assign w_take = |(bus.req_valid & w_req_ready);

  bin_to_ascii u_bin_to_ascii (
    .i_bin   (r_word),
    .o_ascii (w_ascii)
  );

  assign w_next_idx = r_index + 4'd1;

  always_comb begin
    w_next_byte = 8'h00;
    case (w_next_idx)
      4'd0:  w_next_byte = 8'h30 + {4'h0, r_id};
      4'd1:  w_next_byte = 8'h3A;
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8:
             w_next_byte = w_ascii[8*(4'd8 - w_next_idx) +: 8];
      4'd9:  w_next_byte = 8'h0D;
      4'd10: w_next_byte = 8'h0A;
      default: w_next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_index      <= 4'd0;
      r_id         <= 4'd0;
      r_last_grant <= 4'(NUM_REQ - 1);
      r_word       <= 7'd0;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_id         <= w_grant_id;
            r_word       <= bus.req_data[7*w_grant_id +: 7];
            r_last_grant <= w_grant_id;
            r_index      <= 4'd0;
            r_tx_data    <= 8'h30 + {4'h0, w_grant_id};
            r_tx_valid   <= 1'b1;
            r_state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (r_tx_valid && bus.tx_ready) begin
            if (r_index == 4'd10) begin
              r_tx_valid <= 1'b0;
              r_index    <= 4'd0;
              r_state    <= ST_IDLE;
            end else begin
              r_index   <= w_next_idx;
              r_tx_data <= w_next_byte;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.busy      = (r_state == ST_SEND);
endmodule

// File: tb/tb_ascii_dump_sequencer.sv
// Directed bench for ascii_dump_sequencer: record format, round-robin order,
// backpressure, frozen capture, reset mid-record and all-0/all-1 words.
module tb_ascii_dump_sequencer;
  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ascii_dump_sequencer_if #(.NUM_REQ(NUM_REQ)) bus ();

  ascii_dump_sequencer #(.NUM_REQ(NUM_REQ), .DATA_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int busy_cnt;
  int rdy_seen;
  logic [7:0] rx_buf [11];
  logic [7:0] t1_exp [11] = '{8'h30, 8'h3A, 8'h31, 8'h30, 8'h31, 8'h30,
                              8'h30, 8'h31, 8'h31, 8'h0D, 8'h0A};
  logic [6:0] d2 [4] = '{7'h15, 7'h2A, 7'h47, 7'h3C};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int id, input logic [6:0] w, input int n);
    case (n)
      0:       return 8'(8'h30 + id);
      1:       return 8'h3A;
      9:       return 8'h0D;
      10:      return 8'h0A;
      default: return w[8-n] ? 8'h31 : 8'h30;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Collects nbytes of a record starting at the next falling edge.
  task automatic recv_record(input int id, input logic [6:0] word, input bit bp,
                             input bit mut, input int nbytes);
    int n = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [7:0] held = 8'h00;
    busy_cnt = 0;
    rdy_seen = 0;
    while (n < nbytes && cyc < 200) begin
      @(negedge clk);
      if (bp) bus.tx_ready = (cyc >= 5 && cyc < 10) ? 1'b0 : (cyc % 2 == 0);
      else    bus.tx_ready = 1'b1;
      cyc++;
      if (bus.busy) busy_cnt++;
      if (|bus.req_ready) rdy_seen++;
      if (stalled) begin
        check("stall_valid", 32'(bus.tx_valid), 32'd1);
        check("stall_data", 32'(bus.tx_data), 32'(held));
      end
      if (mut && n == 3) bus.req_data[7*id +: 7] = ~word;
      stalled = 1'b0;
      if (bus.tx_valid && bus.tx_ready) begin
        check($sformatf("id%0d_byte%0d", id, n), 32'(bus.tx_data), 32'(exp_byte(id, word, n)));
        rx_buf[n] = bus.tx_data;
        n++;
      end else if (bus.tx_valid) begin
        stalled = 1'b1;
        held    = bus.tx_data;
      end
    end
    check("byte_count", n, nbytes);
    check("ready_in_send", rdy_seen, 0);
    if (nbytes == 11) begin
      @(negedge clk);
      check("end_valid", 32'(bus.tx_valid), 32'd0);
      check("end_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int cnt_v, cnt_r;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_ready  = 1'b0;

    // Reset state, with every requester asking
    rst = 1'b1;
    bus.req_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // 1: single record, word 1010011
    @(negedge clk);
    bus.req_data[6:0] = 7'b1010011;
    bus.req_valid     = 4'b0001;
    bus.tx_ready      = 1'b1;
    #1 check("t1_grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    recv_record(0, 7'b1010011, 1'b0, 1'b0, 11);
    check("t1_busy_cycles", busy_cnt, 11);
    for (int i = 0; i < 11; i++) check($sformatf("t1_vec%0d", i), 32'(rx_buf[i]), 32'(t1_exp[i]));

    // 2: all four continuously -> 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) bus.req_data[7*i +: 7] = d2[i];
    bus.req_valid = 4'hF;
    for (int r = 0; r < 5; r++) begin
      #1 check($sformatf("t2_grant%0d", r), 32'(bus.req_ready), 32'(1 << (r % 4)));
      recv_record(r % 4, d2[r % 4], 1'b0, 1'b0, 11);
    end
    bus.req_valid = '0;

    // 3: backpressure on requester 1
    @(negedge clk);
    bus.req_data[13:7] = 7'h5A;
    bus.req_valid      = 4'b0010;
    #1 check("t3_grant", 32'(bus.req_ready), 32'h2);
    @(posedge clk);
    #1 bus.req_valid = '0;
    recv_record(1, 7'h5A, 1'b1, 1'b0, 11);
    bus.tx_ready = 1'b1;

    // 4: requester 2 word changes mid-record
    do_reset();
    bus.req_data[20:14] = 7'b0110101;
    bus.req_valid       = 4'b0100;
    #1 check("t4_grant", 32'(bus.req_ready), 32'h4);
    @(posedge clk);
    #1 bus.req_valid = '0;
    recv_record(2, 7'b0110101, 1'b0, 1'b1, 11);

    // 5: reset at byte index 5, then requester 3
    do_reset();
    bus.req_data[6:0] = 7'h33;
    bus.req_valid     = 4'b0001;
    #1 check("t5_grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    recv_record(0, 7'h33, 1'b0, 1'b0, 5);
    @(negedge clk);
    check("t5_idx5", 32'(bus.tx_data), 32'(exp_byte(0, 7'h33, 5)));
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(bus.tx_valid), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_data[27:21] = 7'h4E;
    bus.req_valid       = 4'b1000;
    #1 check("t5_grant3", 32'(bus.req_ready), 32'h8);
    @(posedge clk);
    #1 bus.req_valid = '0;
    recv_record(3, 7'h4E, 1'b0, 1'b0, 11);

    // 6: all-zero and all-one words, then silence
    bus.req_data[6:0]  = 7'h00;
    bus.req_data[13:7] = 7'h7F;
    bus.req_valid      = 4'b0011;
    #1 check("t6_grant0", 32'(bus.req_ready), 32'h1);
    recv_record(0, 7'h00, 1'b0, 1'b0, 11);
    #1 check("t6_grant1", 32'(bus.req_ready), 32'h2);
    recv_record(1, 7'h7F, 1'b0, 1'b0, 11);
    bus.req_valid = '0;
    cnt_v = 0;
    cnt_r = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_valid) cnt_v++;
      if (|bus.req_ready) cnt_r++;
    end
    check("t6_quiet_valid", cnt_v, 0);
    check("t6_quiet_ready", cnt_r, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
